// File: rtl/dbus_wb_bridge.sv
// Data-side bridge: MEM-stage RAM request -> registered Wishbone B3 classic master cycle.
// Stalls the pipeline until ack, and holds read data while MEM is frozen by another stall.
// Optional feature: define DBUS_TIMEOUT_EN to terminate unacked cycles after TIMEOUT_CYCLES.
module dbus_wb_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_ce_i,
    input  logic                cpu_we_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    output logic                stallreq_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic                wb_ack_i,
    output logic                bus_err_o
);

    localparam int unsigned SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StWaitRelease
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                stb_q, stb_d;
    logic                cyc_q, cyc_d;
    logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;

    logic mem_hold;
    logic req;
    logic ack_ok;
    logic timeout;

    // Only the MEM-stage hold bit matters to this bridge.
    logic unused_stall;
    assign unused_stall = ^{stall_i[5:4], stall_i[2:0]};

    assign mem_hold = stall_i[3];
    assign req      = cpu_ce_i & ~flush_i;
    assign ack_ok   = (state_q == StBusy) & wb_ack_i & ~flush_i;

`ifdef DBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q;

    // Counter runs only while BUSY without ack; any other cycle (incl. entry) clears it.
    always_comb begin
        cnt_d = '0;
        if (state_q == StBusy && !wb_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The edge that would make the counter reach TIMEOUT_CYCLES ends the cycle.
    assign timeout = (state_q == StBusy) & ~wb_ack_i & ~flush_i &
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter and registered one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= timeout;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    // Parameter only matters when the timeout is built in.
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;

    assign timeout   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // State and Wishbone output registers; reset drops the bus cycle asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    // Next-state, bus register updates and combinational pipeline outputs.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        sel_d      = sel_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        rd_buf_d   = rd_buf_q;
        stallreq_o = 1'b0;
        cpu_data_o = '0;

        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    rd_buf_d = '0;
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                end else if (req) begin
                    stallreq_o = 1'b1;
                    adr_d      = cpu_addr_i;
                    dat_d      = cpu_data_i;
                    we_d       = cpu_we_i;
                    sel_d      = cpu_sel_i;
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    state_d    = StBusy;
                end
            end

            StBusy: begin
                if (flush_i) begin
                    // Flush wins over a coincident ack; the ack is dropped.
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    rd_buf_d = '0;
                    state_d  = StIdle;
                end else if (ack_ok || timeout) begin
                    // A timeout behaves like a read ack returning zero.
                    if (timeout) begin
                        rd_buf_d = '0;
                    end else if (!we_q) begin
                        cpu_data_o = wb_dat_i;
                        rd_buf_d   = wb_dat_i;
                    end
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    state_d = mem_hold ? StWaitRelease : StIdle;
                end else begin
                    stallreq_o = 1'b1;
                end
            end

            StWaitRelease: begin
                if (flush_i) begin
                    rd_buf_d = '0;
                    state_d  = StIdle;
                end else begin
                    cpu_data_o = rd_buf_q;
                    if (!mem_hold) begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = cyc_q;

endmodule
